fp_accum_seq: RTL and testbench
===============================

Name: fp_accum_seq

Overview:
Upstream sequencer for the multi-cycle single-precision adder (start/done handshake). Buffers a valid/ready stream of IEEE-754 words in a small FIFO and issues one add per word, computing acc = acc + x. Frames a reduction with in_last. Delivers each frame's final sum on a valid/ready output port, then clears the accumulator for the next frame.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
CNT_W, 16, width of per-frame element counter
TIMEOUT, 64, max cycles to wait for add_done before flagging error

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input word valid
in_ready  out  1  FIFO not full
in_data  in  32  IEEE-754 single operand
in_last  in  1  word closes the current frame
add_start  out  1  adder start request
add_a  out  32  adder operand A (accumulator)
add_b  out  32  adder operand B (FIFO head)
add_sum  in  32  adder result
add_done  in  1  adder completion flag
out_valid  out  1  frame result valid
out_ready  in  1  downstream accepts result
out_sum  out  32  frame sum
out_count  out  CNT_W  elements in frame
err_timeout  out  1  sticky: adder failed to answer within TIMEOUT

Behaviour:
- Reset (reset=0, async) values: FIFO empty, state IDLE, acc=32'h0, count=0, in_ready=0 during reset then 1, add_start=0, add_a/add_b=0, out_valid=0, out_sum=0, out_count=0, err_timeout=0.
- FIFO: 33-bit entries {last,data}; push when in_valid&&in_ready; in_ready=!full. Read/write pointers wrap mod DEPTH; full/empty from an extra pointer bit. Push and pop in the same cycle while full is legal only if the pop frees a slot that cycle; in_ready stays combinational from registered full only (no push-through when full).
- FSM states:
  - IDLE: if FIFO non-empty -> LOAD.
  - LOAD: pop head into opb/last_q; add_a<=acc, add_b<=head -> ISSUE.
  - ISSUE: add_start=1; add_a/add_b held stable. Wait counter starts at 0. First cycle add_done==1: acc<=add_sum, count<=count+1 (saturates at all-ones) -> RELEASE. If counter reaches TIMEOUT: err_timeout<=1, acc unchanged -> RELEASE.
  - RELEASE: add_start=0; stay until add_done==0, because the adder holds done one extra cycle after start falls. Then go to EMIT if last_q, else IDLE.
  - EMIT: out_valid=1, out_sum=acc, out_count=count. Hold until out_ready. On handshake: acc<=0, count<=0, out_valid<=0 -> IDLE.
- add_a/add_b are registered and change only in LOAD, so the adder samples stable operands in its idle state.
- No add is issued while in EMIT. FIFO keeps accepting up to DEPTH words.
- Latency: 1 word = 1 (LOAD) + adder latency + >=1 (RELEASE) cycles. The frame result appears the cycle after RELEASE exits.
- Zero and special values (NaN/Inf/±0) are passed through the adder unmodified; no local arithmetic beyond the counter.
- in_last on the first word: a single-element frame; result = 0 + x.
- Reset mid-add: all state clears immediately and add_start drops asynchronously. The adder is assumed reset by the same net.
- err_timeout clears only on reset.

Test Plan:
- Frame 1.0 (3F800000), 2.0 (40000000), 3.0 (40400000, last) against real adder -> out_sum=40C00000, out_count=3, single out_valid pulse held until out_ready.
- Single-word frame 0xC0400000 (-3.0, last) -> out_sum=C0400000, out_count=1; next frame starts from acc=0.
- Burst of DEPTH+2 words with out_ready=0 after first frame -> in_ready low when FIFO full; no word lost or duplicated; final sums correct once out_ready=1.
- 1.0 + (-1.0, last) -> out_sum=00000000, out_count=2.
- Stub adder never asserts add_done -> err_timeout=1 at TIMEOUT cycles after add_start rose; FSM continues; acc unchanged.
- Assert reset low during ISSUE -> all outputs at reset values same cycle; after release, a new frame 2.0+2.0 -> 40800000.

Source files
------------

// File: rtl/fp_accum_seq_if.sv
// Bundle of the three handshakes around the accumulation sequencer:
// the incoming operand stream, the start/done adder port and the
// frame-result stream. The sequencer uses the slave view; the
// surrounding environment (stream source, adder, result sink) uses master.
interface fp_accum_seq_if #(
    parameter int CNT_W = 16
);
    // Operand stream
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    // Multi-cycle adder port
    logic             add_start;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             add_done;
    // Frame result stream
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    // Status
    logic             err_timeout;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready,
        output add_start, add_a, add_b,
        input  add_sum, add_done,
        output out_valid, out_sum, out_count,
        input  out_ready,
        output err_timeout
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  add_start, add_a, add_b,
        output add_sum, add_done,
        input  out_valid, out_sum, out_count,
        output out_ready,
        input  err_timeout
    );
endinterface

// File: rtl/fp_accum_seq.sv
// Upstream sequencer for a multi-cycle single-precision adder.
// Words arriving on the operand stream are buffered in a small FIFO and
// folded into an accumulator one add at a time (acc = acc + x). A word
// flagged in_last closes the frame: the final sum and element count are
// offered on the result stream, and the accumulator is cleared once the
// result is taken. No arithmetic happens here; special values pass
// straight through to the adder.
module fp_accum_seq #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    fp_accum_seq_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_RELEASE = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    // Element counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [32:0]      mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [32:0]      head_s;

    // Sequencer state and registered outputs
    state_t           state_r;
    logic [31:0]      acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_q_r;
    logic [TW-1:0]    wait_r;
    logic             add_start_r;
    logic [31:0]      add_a_r;
    logic [31:0]      add_b_r;
    logic             out_valid_r;
    logic [31:0]      out_sum_r;
    logic [CNT_W-1:0] out_count_r;
    logic             err_r;
    logic             rdy_en_r;

    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // in_ready depends only on registered state, so a full FIFO never
    // accepts a word even if the sequencer pops in the same cycle.
    assign push_s  = bus.in_valid && rdy_en_r && !full_s;
    // The only consumer is LOAD, which is entered only with data present.
    assign pop_s   = (state_r == S_LOAD);
    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

    assign bus.in_ready    = rdy_en_r && !full_s;
    assign bus.add_start   = add_start_r;
    assign bus.add_a       = add_a_r;
    assign bus.add_b       = add_b_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_sum     = out_sum_r;
    assign bus.out_count   = out_count_r;
    assign bus.err_timeout = err_r;

    // Hold in_ready low while in reset, open the input one cycle after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
        end
    end

    // FIFO write/read pointer update and entry storage ({last, data}).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 33'h0_0000_0000;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {bus.in_last, bus.in_data};
                wr_ptr_r                <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Sequencer FSM: load operand, run one add, wait for done to clear,
    // then either fetch the next word or present the frame result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            acc_r       <= 32'h0000_0000;
            cnt_r       <= '0;
            last_q_r    <= 1'b0;
            wait_r      <= '0;
            add_start_r <= 1'b0;
            add_a_r     <= 32'h0000_0000;
            add_b_r     <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_sum_r   <= 32'h0000_0000;
            out_count_r <= '0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!empty_s) begin
                        state_r <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // Operands are captured here only, so they stay stable
                    // for the whole time start is high.
                    add_a_r     <= acc_r;
                    add_b_r     <= head_s[31:0];
                    last_q_r    <= head_s[32];
                    wait_r      <= '0;
                    add_start_r <= 1'b1;
                    state_r     <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (bus.add_done) begin
                        acc_r       <= bus.add_sum;
                        cnt_r       <= sat_inc(cnt_r);
                        add_start_r <= 1'b0;
                        state_r     <= S_RELEASE;
                    end else if (wait_r == WAIT_LAST) begin
                        // Give up on this word; the accumulator keeps its value.
                        err_r       <= 1'b1;
                        add_start_r <= 1'b0;
                        state_r     <= S_RELEASE;
                    end else begin
                        wait_r <= wait_r + TW'(1);
                    end
                end

                S_RELEASE: begin
                    // The adder keeps done high a cycle after start falls;
                    // leaving earlier would let a stale done finish the next add.
                    if (!bus.add_done) begin
                        if (last_q_r) begin
                            out_valid_r <= 1'b1;
                            out_sum_r   <= acc_r;
                            out_count_r <= cnt_r;
                            state_r     <= S_EMIT;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                end

                S_EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        acc_r       <= 32'h0000_0000;
                        cnt_r       <= '0;
                        state_r     <= S_IDLE;
                    end
                end

                default: begin
                    state_r     <= S_IDLE;
                    add_start_r <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a behavioural start/done adder
// whose results come from a table of hand-computed IEEE-754 sums.
module tb_fp_accum_seq;

    localparam int CNT_W = 16;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fp_accum_seq_if #(.CNT_W(CNT_W)) bus ();

    fp_accum_seq #(
        .DEPTH   (4),
        .CNT_W   (CNT_W),
        .TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vecs  = 0;
    int fails = 0;

    logic m_dead = 1'b0;
    logic m_busy;
    logic m_hold;
    int   m_cnt;

    // Hand-computed single-precision sums for the operand pairs used here.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case ({a, b})
            64'h00000000_3F800000: r = 32'h3F800000; // 0 + 1
            64'h3F800000_40000000: r = 32'h40400000; // 1 + 2
            64'h40400000_40400000: r = 32'h40C00000; // 3 + 3
            64'h00000000_C0400000: r = 32'hC0400000; // 0 + -3
            64'h3F800000_BF800000: r = 32'h00000000; // 1 + -1
            64'h00000000_40000000: r = 32'h40000000; // 0 + 2
            64'h40000000_40000000: r = 32'h40800000; // 2 + 2
            default:               r = 32'h7FC0DEAD;
        endcase
        return r;
    endfunction

    // Adder model: LAT cycles after seeing start, raise done; keep done
    // while start is high and for one more cycle after start falls.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy       <= 1'b0;
            m_hold       <= 1'b0;
            m_cnt        <= 0;
            bus.add_done <= 1'b0;
            bus.add_sum  <= 32'h0;
        end else if (bus.add_done) begin
            if (!bus.add_start) begin
                if (m_hold) begin
                    bus.add_done <= 1'b0;
                    m_hold       <= 1'b0;
                end else begin
                    m_hold <= 1'b1;
                end
            end
        end else if (m_busy) begin
            if (m_cnt == LAT - 1) begin
                bus.add_done <= 1'b1;
                bus.add_sum  <= ref_add(bus.add_a, bus.add_b);
                m_busy       <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (bus.add_start && !m_dead) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", {31'h0, bus.in_ready}, 32'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [31:0] sum,
                                input logic [31:0] cnt, input int hold);
        int n;
        n = 0;
        while (!bus.out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h1);
        chk({tag, "_sum"}, bus.out_sum, sum);
        chk({tag, "_count"}, 32'(bus.out_count), cnt);
        repeat (hold) @(negedge clk);
        chk({tag, "_held"}, {31'h0, bus.out_valid}, 32'h1);
        chk({tag, "_held_sum"}, bus.out_sum, sum);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, {31'h0, bus.out_valid}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk("rst_add_start", {31'h0, bus.add_start}, 32'h0);
        chk("rst_add_a", bus.add_a, 32'h0);
        chk("rst_add_b", bus.add_b, 32'h0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_sum", bus.out_sum, 32'h0);
        chk("rst_out_count", 32'(bus.out_count), 32'h0);
        chk("rst_err", {31'h0, bus.err_timeout}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, bus.in_ready}, 32'h1);

        // 1.0 + 2.0 + 3.0, result held while out_ready stays low
        push_word(32'h3F800000, 1'b0);
        push_word(32'h40000000, 1'b0);
        push_word(32'h40400000, 1'b1);
        expect_frame("f123", 32'h40C00000, 32'd3, 4);

        // Single-element frame starts from a cleared accumulator
        push_word(32'hC0400000, 1'b1);
        expect_frame("neg3", 32'hC0400000, 32'd1, 0);

        // 1.0 + -1.0
        push_word(32'h3F800000, 1'b0);
        push_word(32'hBF800000, 1'b1);
        expect_frame("cancel", 32'h00000000, 32'd2, 1);

        // Burst against a stalled result port
        push_word(32'h40000000, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        push_word(32'h3F800000, 1'b0);
        push_word(32'h40000000, 1'b0);
        push_word(32'h40400000, 1'b1);
        push_word(32'h3F800000, 1'b0);
        chk("burst_full", {31'h0, bus.in_ready}, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hBF800000;
        bus.in_last  = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("burst_still_full", {31'h0, bus.in_ready}, 32'h0);
        expect_frame("burstA", 32'h40000000, 32'd1, 2);
        push_word(32'hBF800000, 1'b1);
        push_word(32'h40000000, 1'b1);
        expect_frame("burstB", 32'h40C00000, 32'd3, 0);
        expect_frame("burstC", 32'h00000000, 32'd2, 0);
        expect_frame("burstD", 32'h40000000, 32'd1, 0);

        // Adder never answers: timeout after 64 cycles, acc untouched
        m_dead = 1'b1;
        push_word(32'h3F800000, 1'b1);
        n = 0;
        while (!bus.add_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("to_start", {31'h0, bus.add_start}, 32'h1);
        chk("to_b_operand", bus.add_b, 32'h3F800000);
        n = 0;
        while (!bus.err_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd64);
        chk("to_err", {31'h0, bus.err_timeout}, 32'h1);
        expect_frame("to_frame", 32'h00000000, 32'd0, 0);
        m_dead = 1'b0;

        // Sticky error survives a good frame
        push_word(32'h40000000, 1'b1);
        expect_frame("after_to", 32'h40000000, 32'd1, 0);
        chk("err_sticky", {31'h0, bus.err_timeout}, 32'h1);

        // Reset while an add is in flight
        push_word(32'h40000000, 1'b0);
        n = 0;
        while (!bus.add_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_start", {31'h0, bus.add_start}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_start", {31'h0, bus.add_start}, 32'h0);
        chk("mid_rst_a", bus.add_a, 32'h0);
        chk("mid_rst_b", bus.add_b, 32'h0);
        chk("mid_rst_ready", {31'h0, bus.in_ready}, 32'h0);
        chk("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("mid_rst_err", {31'h0, bus.err_timeout}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_word(32'h40000000, 1'b0);
        push_word(32'h40000000, 1'b1);
        expect_frame("post_rst", 32'h40800000, 32'd2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
